stoch_matrix_decode: RTL and testbench

Decodes a NUM_ROWS x NUM_COLS matrix of stochastic bitstreams into binary counts. It sits at the output end of the stochastic matrix multiplier. Each element is counted as the number of ones over a fixed window of 2^WINDOW_LOG cycles, and the finished count matrix is presented on a valid/ready handshake. Software or downstream binary logic turns a count into a probability by dividing it by 2^WINDOW_LOG.

---
 rtl/stoch_matrix_decode.sv | 60 ++++++
 tb/tb_stoch_matrix_decode.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stoch_matrix_decode.sv
// stoch_matrix_decode: counts ones per element of a NUM_ROWS x NUM_COLS stochastic matrix over 2^WINDOW_LOG cycles
// Ports: CLK, RST (sync, active-high); start begins a window from IDLE; abort cancels a window in ACCUM;
// Y carries one stochastic bit per element per cycle; busy is high in ACCUM and HOLD;
// out_valid/out_ready hand over out_data, the per-element ones counts (WINDOW_LOG+1 bits each).
module stoch_matrix_decode #(
    parameter int NUM_ROWS   = 2,
    parameter int NUM_COLS   = 2,
    parameter int WINDOW_LOG = 8
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]             Y,
    output logic                                          busy,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG:0] out_data
);
    localparam int CW = WINDOW_LOG + 1;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t                                  state, state_nx;
    logic [WINDOW_LOG-1:0]                   cyc;
    logic                                    full;
    logic                                    clear, sample;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0] cnt;
    // full marks that the last of the N samples was taken; ACCUM then spends one
    // more cycle without sampling before HOLD, giving out_valid N+1 edges after start
    always_comb begin
        clear    = (state == IDLE && start) || (state == ACCUM && abort);
        sample   = state == ACCUM && !abort && !full;
        state_nx = state == IDLE  ? (start ? ACCUM : IDLE) :
                   state == ACCUM ? (abort ? IDLE : full ? HOLD : ACCUM) :
                                    (out_ready ? IDLE : HOLD);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cyc   <= '0;
            full  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                cyc  <= '0;
                full <= 1'b0;
                cnt  <= '0;
            end else if (sample) begin
                cyc  <= cyc + WINDOW_LOG'(1);
                full <= &cyc;
                for (int i = 0; i < NUM_ROWS; i++)
                    for (int j = 0; j < NUM_COLS; j++)
                        cnt[i][j] <= cnt[i][j] + CW'(Y[i][j]);
            end
        end
    end
    assign busy      = state != IDLE;
    assign out_valid = state == HOLD;
    assign out_data  = cnt;
endmodule

// File: tb/tb_stoch_matrix_decode.sv
// tb_stoch_matrix_decode: directed checks on a 2x2 N=8 decoder and randomized Bernoulli windows on a 2x2 N=256 decoder
module tb_stoch_matrix_decode;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RST;
    logic a_start, a_abort, a_ready, a_busy, a_valid;
    logic [1:0][1:0] a_Y;
    logic [1:0][1:0][3:0] a_data;
    logic b_start, b_abort, b_ready, b_busy, b_valid;
    logic [1:0][1:0] b_Y;
    logic [1:0][1:0][8:0] b_data;
    int checks = 0;
    int failures = 0;

    stoch_matrix_decode #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG(3)) dut_a (
        .CLK(CLK), .RST(RST), .start(a_start), .abort(a_abort), .Y(a_Y),
        .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data));
    stoch_matrix_decode #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG(8)) dut_b (
        .CLK(CLK), .RST(RST), .start(b_start), .abort(b_abort), .Y(b_Y),
        .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // expected counts: number of ones driven on each element over the window
    function automatic logic [15:0] a_ref(input logic [7:0][3:0] pat);
        logic [15:0] r = '0;
        for (int e = 0; e < 4; e++) begin
            int s = 0;
            for (int c = 0; c < 8; c++) s += int'(pat[c][e]);
            r[e*4 +: 4] = 4'(s);
        end
        return r;
    endfunction

    // start a window, drive pat on the 8 cycles after the start edge, then wait for out_valid;
    // lat = edges after the start edge until out_valid is seen (20 means never)
    task automatic a_window(input logic [7:0][3:0] pat, input int abort_at, output int lat);
        a_start = 1'b1;
        @(negedge CLK);
        a_start = 1'b0;
        chk("busy_rise", a_busy, 1);
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            a_Y = pat[c];
            a_abort = (c == abort_at);
            @(negedge CLK);
            lat++;
            if (c == abort_at) break;
        end
        a_abort = 1'b0;
        while (!a_valid && lat < 20) begin
            a_Y = 4'($urandom);
            @(negedge CLK);
            lat++;
        end
    endtask

    initial begin
        logic [7:0][3:0] ones, pat;
        logic [15:0] exp16;
        int lat;
        for (int c = 0; c < 8; c++) ones[c] = 4'hf;
        RST = 1'b1; a_start = 0; a_abort = 0; a_ready = 1; a_Y = '0;
        b_start = 0; b_abort = 0; b_ready = 0; b_Y = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 0);
        chk("rst_b_data", b_data, 0);

        // all ones: latency and full-scale count
        a_window(ones, -1, lat);
        chk("ones_latency", lat, 9);
        chk("ones_data", a_data, {4{4'd8}});
        chk("ones_busy_hold", a_busy, 1);
        @(negedge CLK);
        chk("ones_valid_drop", a_valid, 0);
        chk("ones_busy_drop", a_busy, 0);
        chk("ones_data_kept", a_data, {4{4'd8}});

        // distinct streams: [0][0]=zeros, [0][1]=1010.., [1][0]=single 1, [1][1]=ones
        for (int c = 0; c < 8; c++) pat[c] = {1'b1, c == 0, c % 2 == 0, 1'b0};
        a_window(pat, -1, lat);
        chk("distinct_latency", lat, 9);
        chk("distinct_data", a_data, {4'd8, 4'd1, 4'd4, 4'd0});
        @(negedge CLK);

        // backpressure with start/abort/Y noise during HOLD
        a_ready = 1'b0;
        for (int c = 0; c < 8; c++) pat[c] = 4'($urandom);
        exp16 = a_ref(pat);
        a_window(pat, -1, lat);
        chk("bp_latency", lat, 9);
        for (int k = 0; k < 20; k++) begin
            a_Y = 4'($urandom);
            a_start = 1'($urandom);
            a_abort = 1'($urandom);
            @(negedge CLK);
            chk("bp_valid_held", a_valid, 1);
            chk("bp_data_held", a_data, exp16);
        end
        a_start = 0; a_abort = 0; a_ready = 1'b1;
        @(negedge CLK);
        chk("bp_release_valid", a_valid, 0);
        chk("bp_release_busy", a_busy, 0);
        chk("bp_release_data", a_data, exp16);

        // abort at sample 5 of 8, then a clean window
        a_window(ones, 4, lat);
        chk("abort_no_valid", lat, 20);
        chk("abort_busy", a_busy, 0);
        chk("abort_cleared", a_data, 0);
        a_window(ones, -1, lat);
        chk("post_abort_latency", lat, 9);
        chk("post_abort_data", a_data, {4{4'd8}});
        @(negedge CLK);

        // reset mid-ACCUM
        a_start = 1'b1;
        @(negedge CLK);
        a_start = 1'b0; a_Y = 4'hf;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_accum_busy", a_busy, 0);
        chk("rst_accum_valid", a_valid, 0);
        chk("rst_accum_data", a_data, 0);
        for (int c = 0; c < 8; c++) pat[c] = 4'($urandom);
        a_window(pat, -1, lat);
        chk("rst_accum_next_lat", lat, 9);
        chk("rst_accum_next_data", a_data, a_ref(pat));
        @(negedge CLK);

        // reset mid-HOLD
        a_ready = 1'b0;
        a_window(ones, -1, lat);
        chk("rst_hold_valid_pre", a_valid, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_hold_busy", a_busy, 0);
        chk("rst_hold_valid", a_valid, 0);
        chk("rst_hold_data", a_data, 0);
        a_ready = 1'b1;
        for (int c = 0; c < 8; c++) pat[c] = 4'($urandom);
        a_window(pat, -1, lat);
        chk("rst_hold_next_lat", lat, 9);
        chk("rst_hold_next_data", a_data, a_ref(pat));
        @(negedge CLK);

        // randomized Bernoulli windows, p = k/4 per element
        for (int w = 0; w < 50; w++) begin
            int k[4];
            int exp[4];
            int n;
            for (int e = 0; e < 4; e++) begin
                k[e] = int'($urandom_range(1, 3));
                exp[e] = 0;
            end
            b_start = 1'b1;
            @(negedge CLK);
            b_start = 1'b0;
            for (int c = 0; c < 256; c++) begin
                logic [3:0] y;
                for (int e = 0; e < 4; e++) begin
                    y[e] = int'($urandom_range(0, 3)) < k[e];
                    exp[e] += int'(y[e]);
                end
                b_Y = y;
                @(negedge CLK);
            end
            n = 0;
            while (!b_valid && n < 10) begin
                b_Y = 4'($urandom);
                @(negedge CLK);
                n++;
            end
            chk("rand_latency", n, 1);
            for (int e = 0; e < 4; e++) chk("rand_count", b_data[e/2][e%2], exp[e]);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            b_ready = 1'b1;
            @(negedge CLK);
            b_ready = 1'b0;
            chk("rand_valid_drop", b_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
